// File: rtl/spr_line_eval.sv
// Per-line sprite evaluator: scans sprites 0..63 at each line start and emits one descriptor per hit.
// Optional build macro SPR_LINE_EVAL_OVF_EN: flag, and stop on, a hit found after MAX_PER_LINE descriptors.
module spr_line_eval #(
  parameter int MAX_PER_LINE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       line_start,
  input  logic [7:0] line_num,
  output logic [5:0] spr_sel,
  input  logic [8:0] spr_x,
  input  logic [7:0] spr_y,
  input  logic [8:0] spr_idx,
  input  logic       spr_enable,
  input  logic       spr_priority,
  input  logic [1:0] spr_palette,
  input  logic       spr_h16,
  input  logic       spr_vflip,
  input  logic       spr_hflip,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_x,
  output logic [8:0] out_tile,
  output logic [2:0] out_row,
  output logic [1:0] out_palette,
  output logic       out_priority,
  output logic       out_hflip,
  output logic       done,
  output logic       overflow
);

`ifdef SPR_LINE_EVAL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  localparam logic [6:0] MAX_CNT = 7'(MAX_PER_LINE);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] line_reg, line_next;
  logic [5:0] sel_reg, sel_next;
  logic [6:0] count_reg, count_next;
  logic       fin_reg, fin_next;
  logic       ovf_reg, ovf_next;
  logic       valid_reg, valid_next;
  logic [8:0] x_reg, x_next;
  logic [8:0] tile_reg, tile_next;
  logic [2:0] row_reg, row_next;
  logic [1:0] pal_reg, pal_next;
  logic       pri_reg, pri_next;
  logic       hflip_reg, hflip_next;

  // Intersection test for the sprite currently addressed; dy wraps so sprites straddling line 255 still hit.
  logic [7:0] dy;
  logic       hit;
  logic [3:0] r;
  assign dy  = line_reg - spr_y;
  assign hit = spr_enable && (dy < (spr_h16 ? 8'd16 : 8'd8));
  assign r   = dy[3:0] ^ (spr_vflip ? (spr_h16 ? 4'hF : 4'h7) : 4'h0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      line_reg  <= '0;
      sel_reg   <= '0;
      count_reg <= '0;
      fin_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b0;
      x_reg     <= '0;
      tile_reg  <= '0;
      row_reg   <= '0;
      pal_reg   <= '0;
      pri_reg   <= 1'b0;
      hflip_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      line_reg  <= line_next;
      sel_reg   <= sel_next;
      count_reg <= count_next;
      fin_reg   <= fin_next;
      ovf_reg   <= ovf_next;
      valid_reg <= valid_next;
      x_reg     <= x_next;
      tile_reg  <= tile_next;
      row_reg   <= row_next;
      pal_reg   <= pal_next;
      pri_reg   <= pri_next;
      hflip_reg <= hflip_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    line_next  = line_reg;
    sel_next   = sel_reg;
    count_next = count_reg;
    fin_next   = fin_reg;
    ovf_next   = ovf_reg;
    valid_next = valid_reg;
    x_next     = x_reg;
    tile_next  = tile_reg;
    row_next   = row_reg;
    pal_next   = pal_reg;
    pri_next   = pri_reg;
    hflip_next = hflip_reg;

    case (state_reg)
      SCAN: begin
        // A sprite is only evaluated once the descriptor register is free or being accepted now.
        if (valid_reg && !out_ready) begin
          state_next = HOLD;
        end else begin
          valid_next = 1'b0;
          if (fin_reg) begin
            state_next = DONE;
          end else if (hit) begin
            if (count_reg < MAX_CNT) begin
              valid_next = 1'b1;
              x_next     = spr_x;
              tile_next  = spr_idx + {8'd0, r[3]};
              row_next   = r[2:0];
              pal_next   = spr_palette;
              pri_next   = spr_priority;
              hflip_next = spr_hflip;
              count_next = count_reg + 7'd1;
              if (sel_reg == 6'd63 || (!OVF_EN && count_reg == MAX_CNT - 7'd1))
                fin_next = 1'b1;
              else
                sel_next = sel_reg + 6'd1;
            end else begin
              ovf_next   = OVF_EN;
              state_next = DONE;
            end
          end else if (sel_reg == 6'd63) begin
            state_next = DONE;
          end else begin
            sel_next = sel_reg + 6'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_next = 1'b0;
          state_next = fin_reg ? DONE : SCAN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A new line always wins: any pending descriptor is dropped and the scan restarts.
    if (line_start) begin
      state_next = SCAN;
      line_next  = line_num;
      sel_next   = 6'd0;
      count_next = 7'd0;
      fin_next   = 1'b0;
      ovf_next   = 1'b0;
      valid_next = 1'b0;
    end
  end

  always_comb begin
    spr_sel      = sel_reg;
    out_valid    = valid_reg;
    out_x        = x_reg;
    out_tile     = tile_reg;
    out_row      = row_reg;
    out_palette  = pal_reg;
    out_priority = pri_reg;
    out_hflip    = hflip_reg;
    done         = (state_reg == DONE);
    overflow     = ovf_reg;
  end

endmodule

// File: tb/tb_spr_line_eval.sv
// Directed bench for spr_line_eval with a combinational attribute-store model.
module tb_spr_line_eval;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, line_start, out_ready;
  logic [7:0] line_num;
  logic [5:0] spr_sel;
  logic [8:0] spr_x, spr_idx;
  logic [7:0] spr_y;
  logic       spr_enable, spr_priority, spr_h16, spr_vflip, spr_hflip;
  logic [1:0] spr_palette;
  logic       out_valid, out_priority, out_hflip, done, overflow;
  logic [8:0] out_x, out_tile;
  logic [2:0] out_row;
  logic [1:0] out_palette;

  logic [8:0] m_x   [64];
  logic [7:0] m_y   [64];
  logic [8:0] m_idx [64];
  logic [1:0] m_pal [64];
  logic       m_en  [64];
  logic       m_pri [64];
  logic       m_h16 [64];
  logic       m_vf  [64];
  logic       m_hf  [64];

  assign spr_x        = m_x[spr_sel];
  assign spr_y        = m_y[spr_sel];
  assign spr_idx      = m_idx[spr_sel];
  assign spr_palette  = m_pal[spr_sel];
  assign spr_enable   = m_en[spr_sel];
  assign spr_priority = m_pri[spr_sel];
  assign spr_h16      = m_h16[spr_sel];
  assign spr_vflip    = m_vf[spr_sel];
  assign spr_hflip    = m_hf[spr_sel];

  spr_line_eval #(.MAX_PER_LINE(16)) dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .line_num(line_num),
    .spr_sel(spr_sel), .spr_x(spr_x), .spr_y(spr_y), .spr_idx(spr_idx),
    .spr_enable(spr_enable), .spr_priority(spr_priority), .spr_palette(spr_palette),
    .spr_h16(spr_h16), .spr_vflip(spr_vflip), .spr_hflip(spr_hflip),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_tile(out_tile),
    .out_row(out_row), .out_palette(out_palette), .out_priority(out_priority),
    .out_hflip(out_hflip), .done(done), .overflow(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  logic [24:0] q[$];
  logic [24:0] desc;
  assign desc = {out_x, out_tile, out_row, out_palette, out_priority, out_hflip};

`ifdef SPR_LINE_EVAL_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  function automatic logic [24:0] pk(input logic [8:0] x, input logic [8:0] t, input logic [2:0] r,
                                     input logic [1:0] p, input logic pr, input logic hf);
    return {x, t, r, p, pr, hf};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 64; i++) begin
      m_x[i] = '0; m_y[i] = '0; m_idx[i] = '0; m_pal[i] = '0;
      m_en[i] = 1'b0; m_pri[i] = 1'b0; m_h16[i] = 1'b0; m_vf[i] = 1'b0; m_hf[i] = 1'b0;
    end
  endtask

  task automatic set_spr(input int i, input logic [8:0] x, input logic [7:0] y, input logic [8:0] idx,
                         input logic [1:0] pal, input logic pri, input logic h16, input logic vf,
                         input logic hf);
    m_x[i] = x; m_y[i] = y; m_idx[i] = idx; m_pal[i] = pal; m_en[i] = 1'b1;
    m_pri[i] = pri; m_h16[i] = h16; m_vf[i] = vf; m_hf[i] = hf;
  endtask

  task automatic start_line(input logic [7:0] n);
    line_num   = n;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  // Records every accepted descriptor until done; cyc = edges from the line_start capture edge.
  task automatic collect(input string tag);
    q.delete();
    cyc = 0;
    while (!done && cyc < 300) begin
      if (out_valid && out_ready) q.push_back(desc);
      step();
      cyc++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    $display("%s: %0d descriptors, done after %0d cycles", tag, q.size(), cyc);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 100) begin
      check({tag, "_no_done"}, {31'd0, done}, 32'd0);
      step();
      k++;
    end
    check({tag, "_valid_seen"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; line_start = 1'b0; line_num = '0; out_ready = 1'b1;
    clear_all();
    step(); step(); step();
    check("reset_outputs", {4'd0, spr_sel, out_valid, desc, done, overflow}, 32'd0);
    reset_n = 1'b1;
    step();
    check("idle_after_reset", {4'd0, spr_sel, out_valid, desc, done, overflow}, 32'd0);

    // Single 8-tall sprite, dy=3
    set_spr(5, 9'h123, 8'd10, 9'h020, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    start_line(8'd13);
    collect("t1");
    check("t1_cycles", cyc, 64);
    check("t1_count", q.size(), 1);
    if (q.size() > 0) check("t1_desc", {7'd0, q[0]}, {7'd0, pk(9'h123, 9'h020, 3'd3, 2'd2, 1'b1, 1'b1)});
    check("t1_sel_end", {26'd0, spr_sel}, 32'd63);
    check("t1_overflow", {31'd0, overflow}, 32'd0);

    // 16-tall vflip, tile index wraps past 0x1FF
    clear_all();
    set_spr(0, 9'h1F0, 8'd100, 9'h1FF, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    start_line(8'd102);
    collect("t2");
    check("t2_cycles", cyc, 64);
    check("t2_count", q.size(), 1);
    if (q.size() > 0) check("t2_desc", {7'd0, q[0]}, {7'd0, pk(9'h1F0, 9'h000, 3'd5, 2'd3, 1'b0, 1'b0)});

    // 20 hits against a limit of 16
    clear_all();
    for (int i = 0; i < 20; i++)
      set_spr(i, 9'(i + 'h40), 8'd48, 9'(2 * i), 2'(i), 1'((i >> 0) & 1), 1'b0, 1'b0, 1'((i >> 1) & 1));
    start_line(8'd50);
    collect("t3");
    check("t3_cycles", cyc, 17);
    check("t3_count", q.size(), 16);
    for (int j = 0; j < 16; j++)
      if (j < q.size())
        check($sformatf("t3_desc%0d", j), {7'd0, q[j]},
              {7'd0, pk(9'(j + 'h40), 9'(2 * j), 3'd2, 2'(j), 1'(j & 1), 1'((j >> 1) & 1))});
    check("t3_overflow", {31'd0, overflow}, {31'd0, EXP_OVF});
    step();
    check("t3_overflow_held", {31'd0, overflow}, {31'd0, EXP_OVF});

    // Back-pressure on the first descriptor
    clear_all();
    set_spr(2, 9'h0AA, 8'd48, 9'h011, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    set_spr(7, 9'h0BB, 8'd48, 9'h022, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    out_ready = 1'b0;
    start_line(8'd50);
    check("t4_overflow_cleared", {31'd0, overflow}, 32'd0);
    wait_valid("t4");
    for (int s = 0; s < 5; s++) begin
      check($sformatf("t4_hold_valid%0d", s), {31'd0, out_valid}, 32'd1);
      check($sformatf("t4_hold_desc%0d", s), {7'd0, desc}, {7'd0, pk(9'h0AA, 9'h011, 3'd2, 2'd1, 1'b1, 1'b0)});
      check($sformatf("t4_hold_sel%0d", s), {26'd0, spr_sel}, 32'd3);
      step();
    end
    out_ready = 1'b1;
    collect("t4");
    check("t4_count", q.size(), 2);
    if (q.size() > 1) begin
      check("t4_desc0", {7'd0, q[0]}, {7'd0, pk(9'h0AA, 9'h011, 3'd2, 2'd1, 1'b1, 1'b0)});
      check("t4_desc1", {7'd0, q[1]}, {7'd0, pk(9'h0BB, 9'h022, 3'd5, 2'd2, 1'b0, 1'b1)});
    end

    // Y wrap: dy=8 hits only a 16-tall sprite
    clear_all();
    set_spr(3, 9'h0F0, 8'd250, 9'h040, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    start_line(8'd2);
    collect("t5a");
    check("t5a_count", q.size(), 1);
    if (q.size() > 0) check("t5a_desc", {7'd0, q[0]}, {7'd0, pk(9'h0F0, 9'h041, 3'd0, 2'd1, 1'b0, 1'b0)});
    m_h16[3] = 1'b0;
    start_line(8'd2);
    collect("t5b");
    check("t5b_count", q.size(), 0);
    check("t5b_cycles", cyc, 64);

    // Abort a held descriptor with a new line_start
    clear_all();
    set_spr(10, 9'h10A, 8'd48, 9'h0A0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_spr(1, 9'h101, 8'd78, 9'h0B0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    start_line(8'd50);
    wait_valid("t6");
    step();
    start_line(8'd80);
    check("t6_abort_valid", {31'd0, out_valid}, 32'd0);
    check("t6_abort_sel", {26'd0, spr_sel}, 32'd0);
    check("t6_abort_done", {31'd0, done}, 32'd0);
    out_ready = 1'b1;
    collect("t6");
    check("t6_cycles", cyc, 64);
    check("t6_count", q.size(), 1);
    if (q.size() > 0) check("t6_desc", {7'd0, q[0]}, {7'd0, pk(9'h101, 9'h0B0, 3'd2, 2'd3, 1'b1, 1'b0)});

    // Asynchronous reset while a descriptor is held
    out_ready = 1'b0;
    start_line(8'd50);
    wait_valid("t7");
    step();
    #2 reset_n = 1'b0;
    #1 check("t7_async_reset", {4'd0, spr_sel, out_valid, desc, done, overflow}, 32'd0);
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step(); step(); step();
    check("t7_idle_after", {4'd0, spr_sel, out_valid, desc, done, overflow}, 32'd0);
    start_line(8'd80);
    collect("t7");
    check("t7_count", q.size(), 1);
    if (q.size() > 0) check("t7_desc", {7'd0, q[0]}, {7'd0, pk(9'h101, 9'h0B0, 3'd2, 2'd3, 1'b1, 1'b0)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
